adc_frontend_ctrl: RTL and testbench

- Sample-timing and serial readout controller for the lock-in's 16-bit SAR ADC.
- Drives the ADC pins CONVST, SCLK and SDI, and captures SDO.
- Outputs one parallel sample per sample period, with a single-cycle valid strobe, to the downstream demodulator/mixer.
- Replaces the ad-hoc pin toggling used during board bring-up with a deterministic, fixed-rate acquisition stage.

---
 rtl/adc_frontend_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_adc_frontend_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_frontend_ctrl.sv
// adc_frontend_ctrl
//   Fixed-rate acquisition controller for a 16-bit SAR ADC. A free-running
//   timer issues one trigger per SAMPLE_PERIOD cycles. Each trigger pulses
//   CONVST for CONV_CYCLES cycles, clocks DATA_W bits out of the ADC (MSB
//   first), then presents the word on SAMPLE with a one-cycle SAMPLE_VALID.
//
//   Ports:
//     CLK36        in   36 MHz system clock, rising edge
//     RST_N        in   asynchronous active-low reset
//     ENABLE       in   run the acquisition timer
//     OVR_CLR      in   one-cycle pulse, clears OVERRUN
//     SDO          in   ADC serial data (changes on SCLK falling edge)
//     CONVST       out  ADC conversion start
//     SCLK         out  ADC serial clock, idles low
//     SDI          out  ADC config/chain input, tied high
//     SAMPLE       out  last captured word
//     SAMPLE_VALID out  one-cycle strobe when SAMPLE updates
//     OVERRUN      out  sticky: a trigger arrived while a frame was busy
//
//   Build option:
//     ADC_SIGNED_OUT_EN  when defined, SAMPLE is two's complement (MSB of
//                        the offset-binary ADC word inverted).

module adc_frontend_ctrl #(
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned SCLK_DIV      = 1,
  parameter int unsigned CONV_CYCLES   = 26,
  parameter int unsigned SAMPLE_PERIOD = 72
) (
  input  logic              CLK36,
  input  logic              RST_N,
  input  logic              ENABLE,
  input  logic              OVR_CLR,
  input  logic              SDO,
  output logic              CONVST,
  output logic              SCLK,
  output logic              SDI,
  output logic [DATA_W-1:0] SAMPLE,
  output logic              SAMPLE_VALID,
  output logic              OVERRUN
);

  localparam int unsigned TCNT_W = $clog2(SAMPLE_PERIOD + 1);
  localparam int unsigned CONV_W = $clog2(CONV_CYCLES + 1);
  localparam int unsigned DIV_W  = $clog2(SCLK_DIV + 1);
  localparam int unsigned BIT_W  = $clog2(DATA_W + 1);

  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(SAMPLE_PERIOD - 1);
  localparam logic [CONV_W-1:0] CONV_LOAD = CONV_W'(CONV_CYCLES - 1);
  localparam logic [DIV_W-1:0]  DIV_LOAD  = DIV_W'(SCLK_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LOAD  = BIT_W'(DATA_W);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t              state_q,   state_d;
  logic [TCNT_W-1:0]   tcnt_q,    tcnt_d;
  logic [CONV_W-1:0]   conv_cnt_q, conv_cnt_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   shreg_q,   shreg_d;
  logic [DATA_W-1:0]   sample_q,  sample_d;
  logic                convst_q,  convst_d;
  logic                sclk_q,    sclk_d;
  logic                valid_q,   valid_d;
  logic                overrun_q, overrun_d;
  logic                trigger;
  logic                drop;

  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    conv_cnt_d = conv_cnt_q;
    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    sample_d   = sample_q;
    convst_d   = convst_q;
    sclk_d     = sclk_q;
    valid_d    = 1'b0;

    // Timer parks at 0 while disabled so re-enabling triggers immediately.
    trigger = ENABLE && (tcnt_q == '0);
    if (!ENABLE) begin
      tcnt_d = '0;
    end else if (tcnt_q == TCNT_LAST) begin
      tcnt_d = '0;
    end else begin
      tcnt_d = tcnt_q + 1'b1;
    end

    // A set in the same cycle as OVR_CLR keeps the flag high.
    drop      = trigger && (state_q != ST_IDLE);
    overrun_d = drop | (overrun_q & ~OVR_CLR);

    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          state_d    = ST_CONV;
          convst_d   = 1'b1;
          conv_cnt_d = CONV_LOAD;
        end
      end
      ST_CONV: begin
        if (conv_cnt_q == '0) begin
          state_d   = ST_SHIFT;
          convst_d  = 1'b0;
          sclk_d    = 1'b0;
          div_cnt_d = DIV_LOAD;
          bit_cnt_d = BIT_LOAD;
        end else begin
          conv_cnt_d = conv_cnt_q - 1'b1;
        end
      end
      ST_SHIFT: begin
        if (div_cnt_q == '0) begin
          div_cnt_d = DIV_LOAD;
          sclk_d    = ~sclk_q;
          // End of a high phase: SDO has been stable since the previous
          // falling edge, so capture it here as SCLK drops.
          if (sclk_q) begin
            shreg_d   = {shreg_q[DATA_W-2:0], SDO};
            bit_cnt_d = bit_cnt_q - 1'b1;
            if (bit_cnt_q == BIT_LAST) begin
              state_d = ST_DONE;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
`ifdef ADC_SIGNED_OUT_EN
        sample_d = {~shreg_q[DATA_W-1], shreg_q[DATA_W-2:0]};
`else
        sample_d = shreg_q;
`endif
        valid_d  = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK36 or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      tcnt_q     <= '0;
      conv_cnt_q <= '0;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      sample_q   <= '0;
      convst_q   <= 1'b0;
      sclk_q     <= 1'b0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      conv_cnt_q <= conv_cnt_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      sample_q   <= sample_d;
      convst_q   <= convst_d;
      sclk_q     <= sclk_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign CONVST       = convst_q;
  assign SCLK         = sclk_q;
  assign SDI          = 1'b1;
  assign SAMPLE       = sample_q;
  assign SAMPLE_VALID = valid_q;
  assign OVERRUN      = overrun_q;

endmodule

// File: tb/tb_adc_frontend_ctrl.sv
module tb_adc_frontend_ctrl;

  localparam int unsigned NV = 8;

  logic clk = 1'b0;
  always #14 clk = ~clk;

  // main instance (defaults)
  logic        rst_n, enable, ovr_clr;
  logic        sdo = 1'b0;
  logic        conv, sclk, sdi, valid, overrun;
  logic [15:0] sample;

  // overrun instance (short period)
  logic        rst2_n, en2, clr2;
  logic        sdo2 = 1'b0;
  logic        conv2, sclk2, sdi2, valid2, ov2;
  logic [15:0] sample2;

  adc_frontend_ctrl dut (
    .CLK36(clk), .RST_N(rst_n), .ENABLE(enable), .OVR_CLR(ovr_clr), .SDO(sdo),
    .CONVST(conv), .SCLK(sclk), .SDI(sdi), .SAMPLE(sample),
    .SAMPLE_VALID(valid), .OVERRUN(overrun)
  );

  adc_frontend_ctrl #(.SAMPLE_PERIOD(40)) dut_ovr (
    .CLK36(clk), .RST_N(rst2_n), .ENABLE(en2), .OVR_CLR(clr2), .SDO(sdo2),
    .CONVST(conv2), .SCLK(sclk2), .SDI(sdi2), .SAMPLE(sample2),
    .SAMPLE_VALID(valid2), .OVERRUN(ov2)
  );

  typedef struct {
    logic [15:0] word;
    logic [15:0] exp_raw;
    logic [15:0] exp_signed;
  } vec_t;

  typedef struct {
    logic [15:0] exp;
    int unsigned due;
  } sb_t;

  vec_t vecs [NV];
  sb_t  sb_q [$];
  sb_t  sb_e;

  int unsigned n_checks = 0, n_pass = 0;
  int unsigned cyc = 0, n_valid = 0, n_rise = 0, n_fall = 0, frame_idx = 0;
  int unsigned rise_cyc = 0, last_rise = 0, sclk_rises = 0;
  bit          last_rise_ok = 1'b0;
  logic        conv_p = 1'b0, sclk_p = 1'b0, valid_p = 1'b0;
  logic [15:0] cur_word = '0, adc_sh = '0, last_sample = '0, exp_w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [15:0] exp_of(input vec_t v);
`ifdef ADC_SIGNED_OUT_EN
    return v.exp_signed;
`else
    return v.exp_raw;
`endif
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor, ADC model and scoreboard, all on the falling clock edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (conv && !conv_p) begin
        n_rise++;
        if (last_rise_ok) check("convst_period", cyc - last_rise, 72);
        last_rise    = cyc;
        last_rise_ok = 1'b1;
        rise_cyc     = cyc;
        sclk_rises   = 0;
        check("sample_held", sample, last_sample);
        if (frame_idx < NV) begin
          cur_word = vecs[frame_idx].word;
          exp_w    = exp_of(vecs[frame_idx]);
        end else begin
          cur_word = 16'($urandom);
`ifdef ADC_SIGNED_OUT_EN
          exp_w = cur_word ^ 16'h8000;
`else
          exp_w = cur_word;
`endif
        end
        frame_idx++;
        sb_q.push_back('{exp: exp_w, due: cyc + 59});
      end
      if (!conv && conv_p) begin
        n_fall++;
        check("convst_width", cyc - rise_cyc, 26);
      end
      if (sclk && !sclk_p) sclk_rises++;
      if (valid) begin
        n_valid++;
        check("valid_single_cycle", valid_p, 0);
        check("sb_nonempty", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          sb_e = sb_q.pop_front();
          check("sample_value", sample, sb_e.exp);
          check("valid_latency", cyc, sb_e.due);
        end
        check("sclk_rises", sclk_rises, 16);
        check("sclk_idle_low", sclk, 0);
        check("overrun_main", overrun, 0);
        last_sample = sample;
      end
    end
    // ADC model: MSB presented when conversion ends, next bit after each SCLK fall.
    if (!conv && conv_p) begin
      adc_sh = cur_word;
      sdo    = adc_sh[15];
    end else if (!sclk && sclk_p) begin
      adc_sh = {adc_sh[14:0], 1'b0};
      sdo    = adc_sh[15];
    end
    conv_p  = conv;
    sclk_p  = sclk;
    valid_p = valid;
  end

  task automatic wait_valids(input int unsigned n);
    int unsigned v0 = n_valid;
    int unsigned t = 0;
    while (n_valid < v0 + n && t < 200 * n) begin
      @(posedge clk);
      t++;
    end
    check("wait_valid_in_time", n_valid >= v0 + n, 1);
  endtask

  task automatic wait_fall();
    int unsigned f0 = n_fall;
    int unsigned t = 0;
    while (n_fall == f0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    check("wait_convst_fall_in_time", n_fall != f0, 1);
  endtask

  int unsigned r0, v0, en_cyc, t;

  initial begin
    vecs[0] = '{16'hA5C3, 16'hA5C3, 16'h25C3};
    vecs[1] = '{16'h8000, 16'h8000, 16'h0000};
    vecs[2] = '{16'h0000, 16'h0000, 16'h8000};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 16'h7FFF};
    vecs[4] = '{16'h1234, 16'h1234, 16'h9234};
    vecs[5] = '{16'h7FFF, 16'h7FFF, 16'hFFFF};
    vecs[6] = '{16'h0001, 16'h0001, 16'h8001};
    vecs[7] = '{16'hFFFE, 16'hFFFE, 16'h7FFE};

    rst_n = 1'b0; enable = 1'b0; ovr_clr = 1'b0;
    rst2_n = 1'b0; en2 = 1'b0; clr2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_convst", conv, 0);
    check("rst_sclk", sclk, 0);
    check("rst_sdi", sdi, 1);
    check("rst_sample", sample, 16'h0000);
    check("rst_valid", valid, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1; rst2_n = 1'b1;
    @(negedge clk);
    enable = 1'b1;

    // Table vectors, one frame each, then more free-running frames.
    for (int i = 0; i < int'(NV); i++) wait_valids(1);
    wait_valids(4);
    check("overrun_free_run", overrun, 0);

    // ENABLE dropped 10 cycles into SHIFT.
    wait_fall();
    repeat (10) @(negedge clk);
    enable = 1'b0;
    last_rise_ok = 1'b0;
    r0 = n_rise;
    wait_valids(1);
    repeat (150) @(negedge clk);
    check("no_convst_while_disabled", n_rise, r0);
    enable = 1'b1;
    en_cyc = cyc;
    t = 0;
    while (n_rise == r0 && t < 20) begin
      @(posedge clk);
      t++;
    end
    check("reenable_rise_seen", n_rise != r0, 1);
    check("reenable_rise_cycle", rise_cyc, en_cyc + 1);
    wait_valids(1);

    // Reset mid-SHIFT while SCLK is high.
    wait_fall();
    repeat (9) @(negedge clk);
    check("sclk_high_before_reset", sclk, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_convst", conv, 0);
    check("midrst_sclk", sclk, 0);
    check("midrst_sdi", sdi, 1);
    check("midrst_sample", sample, 16'h0000);
    check("midrst_valid", valid, 0);
    check("midrst_overrun", overrun, 0);
    sb_q.delete();
    last_rise_ok = 1'b0;
    last_sample = '0;
    v0 = n_valid;
    repeat (5) @(negedge clk);
    check("no_valid_for_aborted_frame", n_valid, v0);
    rst_n = 1'b1;
    wait_valids(2);

    // Overrun with a 40-cycle period: drops at edges 41 and 121.
    @(negedge clk);
    en2 = 1'b1;
    for (int k = 1; k <= 125; k++) begin
      @(negedge clk);
      if (k == 40) check("ovr_before_drop", ov2, 0);
      if (k == 41) check("ovr_set_on_drop", ov2, 1);
      if (k == 59) begin
        check("ovr_sticky", ov2, 1);
        clr2 = 1'b1;
      end
      if (k == 60) begin
        clr2 = 1'b0;
        check("ovr_cleared", ov2, 0);
      end
      if (k == 120) begin
        check("ovr_still_clear", ov2, 0);
        clr2 = 1'b1;
      end
      if (k == 121) begin
        clr2 = 1'b0;
        check("ovr_set_wins_over_clr", ov2, 1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
